// File: rtl/tt_lpf_pi.sv
// Loop-filter PI controller: bang-bang phase-detector error into a clamped integrator and clamped control word.
// Optional integrator scan chain is built only when TT_LPF_SCAN_EN is defined.
module tt_lpf_pi #(
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 16,
  parameter int GAIN_W      = 8,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic [GAIN_W-1:0]        i_kp,
  input  logic [GAIN_W-1:0]        i_ki,
  input  logic                     i_hold,
  output logic signed [OUT_W-1:0]  o_ctrl,
  output logic                     o_sat,
  output logic                     o_locked,
  input  logic                     i_scan_en,
  input  logic                     i_scan_in,
  output logic                     o_scan_out
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);
  localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] ACC_MIN = (ACC_W+1)'(-(64'sd1 <<< (ACC_W-1)));
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        lock_cnt;
  logic [1:0]              err;      // 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
  logic signed [ACC_W:0]   acc_ext, ki_ext, kp_ext, ki_term, kp_term, sum_i, sum_p;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [OUT_W-1:0] out_nxt;
  logic                    acc_clamp, out_clamp;
  logic [CNT_W-1:0]        cnt_nxt;

  assign acc_ext = $signed({acc[ACC_W-1], acc});
  assign ki_ext  = $signed({{(ACC_W+1-GAIN_W){1'b0}}, i_ki});
  assign kp_ext  = $signed({{(ACC_W+1-GAIN_W){1'b0}}, i_kp});

  always_comb begin
    err = 2'b00;
    case ({i_up, i_down})
      2'b10:   err = 2'b11;
      2'b01:   err = 2'b01;
      default: err = 2'b00;
    endcase
  end

  always_comb begin
    ki_term = '0;
    kp_term = '0;
    case (err)
      2'b01: begin
        ki_term = ki_ext;
        kp_term = kp_ext;
      end
      2'b11: begin
        ki_term = -ki_ext;
        kp_term = -kp_ext;
      end
      default: begin
        ki_term = '0;
        kp_term = '0;
      end
    endcase
  end

  // Sums cannot wrap at ACC_W+1 bits because GAIN_W+2 <= ACC_W.
  assign sum_i = acc_ext + ki_term;
  assign sum_p = acc_ext + kp_term;

  always_comb begin
    acc_nxt   = sum_i[ACC_W-1:0];
    acc_clamp = 1'b0;
    if (sum_i > ACC_MAX) begin
      acc_nxt   = ACC_MAX[ACC_W-1:0];
      acc_clamp = 1'b1;
    end else if (sum_i < ACC_MIN) begin
      acc_nxt   = ACC_MIN[ACC_W-1:0];
      acc_clamp = 1'b1;
    end else begin
      acc_nxt   = sum_i[ACC_W-1:0];
      acc_clamp = 1'b0;
    end
  end

  always_comb begin
    out_nxt   = sum_p[OUT_W-1:0];
    out_clamp = 1'b0;
    if (sum_p > OUT_MAX) begin
      out_nxt   = OUT_MAX[OUT_W-1:0];
      out_clamp = 1'b1;
    end else if (sum_p < OUT_MIN) begin
      out_nxt   = OUT_MIN[OUT_W-1:0];
      out_clamp = 1'b1;
    end else begin
      out_nxt   = sum_p[OUT_W-1:0];
      out_clamp = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = lock_cnt;
    if (err != 2'b00) begin
      cnt_nxt = '0;
    end else if (lock_cnt == LOCK_MAX) begin
      cnt_nxt = lock_cnt;
    end else begin
      cnt_nxt = lock_cnt + CNT_W'(1);
    end
  end

  // Priority: reset, then scan shift, then hold/integrate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc      <= '0;
      lock_cnt <= '0;
      o_ctrl   <= '0;
      o_sat    <= 1'b0;
      o_locked <= 1'b0;
`ifdef TT_LPF_SCAN_EN
    end else if (i_scan_en) begin
      acc <= {acc[ACC_W-2:0], i_scan_in};
`endif
    end else begin
      if (!i_hold) begin
        acc <= acc_nxt;
      end
      o_ctrl   <= out_nxt;
      o_sat    <= (acc_clamp & ~i_hold) | out_clamp;
      lock_cnt <= cnt_nxt;
      o_locked <= (cnt_nxt == LOCK_MAX);
    end
  end

`ifdef TT_LPF_SCAN_EN
  assign o_scan_out = acc[ACC_W-1];
`else
  logic unused_scan;
  assign unused_scan = i_scan_en ^ i_scan_in;
  assign o_scan_out  = 1'b0;
`endif

endmodule

// File: tb/tb_tt_lpf_pi.sv
// Bench for tt_lpf_pi: vector table plus hand-built sequences, checked through an expected-result queue.
module tb_tt_lpf_pi;

  typedef struct {
    logic              rst, up, down, hold, scan_en, scan_in;
    logic [7:0]        kp, ki;
    logic signed [15:0] ctrl;
    logic              sat, locked;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, up = 1'b0, down = 1'b0, hold = 1'b0, scan_en = 1'b0, scan_in = 1'b0;
  logic [7:0] kp = 8'd0, ki = 8'd0;
  logic signed [15:0] ctrl;
  logic sat, locked, scan_out;

  logic rst12 = 1'b0, up12 = 1'b0, down12 = 1'b0;
  logic [7:0] kp12 = 8'd0, ki12 = 8'd0;
  logic signed [11:0] ctrl12;
  logic sat12, locked12, scan_out12;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t sb[$];

  tt_lpf_pi dut (
    .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_kp(kp), .i_ki(ki),
    .i_hold(hold), .o_ctrl(ctrl), .o_sat(sat), .o_locked(locked),
    .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(scan_out)
  );

  tt_lpf_pi #(.ACC_W(12), .OUT_W(12), .GAIN_W(8), .LOCK_CYCLES(4)) dut12 (
    .i_clk(clk), .i_rst(rst12), .i_up(up12), .i_down(down12), .i_kp(kp12), .i_ki(ki12),
    .i_hold(1'b0), .o_ctrl(ctrl12), .o_sat(sat12), .o_locked(locked12),
    .i_scan_en(1'b0), .i_scan_in(1'b0), .o_scan_out(scan_out12)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, u, d, h, input logic [7:0] p, i,
                              input logic signed [15:0] c, input logic s, l);
    vec_t v;
    v.rst = r; v.up = u; v.down = d; v.hold = h; v.scan_en = 1'b0; v.scan_in = 1'b0;
    v.kp = p; v.ki = i; v.ctrl = c; v.sat = s; v.locked = l;
    return v;
  endfunction

  // Drive one cycle on the selected instance, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v, input bit sel12, input string name);
    vec_t e;
    if (sel12) begin
      rst12 = v.rst; up12 = v.up; down12 = v.down; kp12 = v.kp; ki12 = v.ki;
    end else begin
      rst = v.rst; up = v.up; down = v.down; hold = v.hold; kp = v.kp; ki = v.ki;
      scan_en = v.scan_en; scan_in = v.scan_in;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel12) begin
      check({name, ".ctrl"}, longint'(ctrl12), longint'(e.ctrl));
      check({name, ".sat"}, longint'(sat12), longint'(e.sat));
    end else begin
      check({name, ".ctrl"}, longint'(ctrl), longint'(e.ctrl));
      check({name, ".sat"}, longint'(sat), longint'(e.sat));
      check({name, ".locked"}, longint'(locked), longint'(e.locked));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    vec_t v;
    logic [23:0] pat;
    pat = 24'hA5A5A5;
    //          rst   up    down  hold  kp     ki     ctrl       sat   locked
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd0,    1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd7,   8'd4, 16'sd7,    1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd7,   8'd4, 16'sd11,   1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd7,   8'd4, 16'sd15,   1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd12,   1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd12,   1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd7,   8'd4, 16'sd19,   1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd7,   8'd4, 16'sd19,   1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd7,   8'd4, 16'sd19,   1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd16,   1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd9,    1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd7,   8'd4, 16'sd12,   1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0, 16'sd12,   1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0, -16'sd243, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd0,    1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd7,   8'd4, 16'sd0,    1'b0, 1'b0);

    for (int i = 0; i < 16; i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Hold freezes the integrator at 100 while the proportional path still acts.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd0,   1'b0, 1'b0), 1'b0, "hold_rst");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd100, 16'sd0,   1'b0, 1'b0), 1'b0, "hold_load");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 8'd100, 16'sd107, 1'b0, 1'b0), 1'b0, "hold_a");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 8'd100, 16'sd107, 1'b0, 1'b0), 1'b0, "hold_b");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1,   16'sd100, 1'b0, 1'b0), 1'b0, "hold_rel");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd101, 1'b0, 1'b0), 1'b0, "hold_resume");

    // Lock after 64 idle edges, coincident up+down keeps lock.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd0, 1'b0, 1'b0), 1'b0, "lock_rst");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd100, 16'sd0, 1'b0, 1'b0), 1'b0, "lock_load");
    for (int k = 1; k <= 64; k++)
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, (k == 64)), 1'b0,
            $sformatf("lock_idle%0d", k));
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, 1'b1), 1'b0, "lock_both");

    // Synchronous reset: nothing moves until the edge.
    rst = 1'b1;
    #2;
    check("srst_pre.ctrl", longint'(ctrl), 64'sd100);
    check("srst_pre.locked", longint'(locked), 64'sd1);
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b0, "srst_edge");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b0, "srst_after");

    for (int k = 2; k <= 64; k++)
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, (k == 64)), 1'b0,
            $sformatf("relock%0d", k));
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b0, "unlock_up");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b0, "unlock_idle");

    // Anti-windup on the 12-bit instance.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b1, "aw_rst");
    for (int k = 1; k <= 9; k++)
      apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd255, 16'(255 * (k - 1)), (k == 9), 1'b0), 1'b1,
            $sformatf("aw_down%0d", k));
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0,   16'sd2047, 1'b1, 1'b0), 1'b1, "aw_outclamp");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 16'sd2047, 1'b0, 1'b0), 1'b1, "aw_up");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd1792, 1'b0, 1'b0), 1'b1, "aw_idle");

    // Scan chain.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd0,   1'b0, 1'b0), 1'b0, "scan_rst");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd100, 16'sd0,   1'b0, 1'b0), 1'b0, "scan_load");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   16'sd100, 1'b0, 1'b0), 1'b0, "scan_pre");
`ifdef TT_LPF_SCAN_EN
    for (int k = 0; k < 24; k++) begin
      v = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, 1'b0);
      v.scan_en = 1'b1;
      v.scan_in = pat[23-k];
      apply(v, 1'b0, $sformatf("scan_in%0d", k));
    end
    for (int k = 0; k < 24; k++) begin
      check($sformatf("scan_out%0d", k), longint'(scan_out), longint'(pat[23-k]));
      v = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, 1'b0);
      v.scan_en = 1'b1;
      apply(v, 1'b0, $sformatf("scan_shift%0d", k));
    end
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd0, 1'b0, 1'b0), 1'b0, "scan_post");
`else
    for (int k = 0; k < 4; k++) begin
      v = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, 1'b0);
      v.scan_en = 1'b1;
      v.scan_in = 1'b1;
      apply(v, 1'b0, $sformatf("noscan%0d", k));
      check($sformatf("noscan_out%0d", k), longint'(scan_out), 64'sd0);
    end
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'sd100, 1'b0, 1'b0), 1'b0, "noscan_post");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
